// File: rtl/mwmon_pkg.sv
// Shared types and helpers for the data-memory write monitor.
// Holds the run-state encoding, the index-width rule and the scratch-window test.
package mwmon_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RUN  = 3'd1,
      PASS = 3'd2,
      FAIL = 3'd3,
      TOUT = 3'd4
   } mwmon_state_e;

   // Table index width; a single-entry table still gets a one-bit index.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // An address with X/Z bits yields an unknown result, which callers treat as "not ignored".
   function automatic logic in_ignore(input logic [63:0] addr,
                                      input logic [63:0] lo,
                                      input logic [63:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/mem_write_monitor_if.sv
// Processor data-memory write port (MemWrite/DataAdr/WriteData) as seen by the monitor.
// The core drives it through master; the monitor only observes through slave.
interface mem_write_monitor_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              MemWrite;
   logic [ADDR_W-1:0] DataAdr;
   logic [DATA_W-1:0] WriteData;

   modport master (output MemWrite, output DataAdr, output WriteData);
   modport slave  (input  MemWrite, input  DataAdr, input  WriteData);
endinterface

// File: rtl/mwmon_table.sv
// Expected-write register file: one synchronous write port, one combinational read port.
// Read data is available in the same cycle; cleared synchronously on reset.
module mwmon_table #(
   parameter int DEPTH = 4,
   parameter int IDX_W = 2,
   parameter int W     = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [IDX_W-1:0] widx,
   input  logic [W-1:0]     wdat,
   input  logic [IDX_W-1:0] ridx,
   output logic [W-1:0]     rdat
);
   localparam logic [IDX_W:0] DEPTH_V = (IDX_W + 1)'(DEPTH);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we && ({1'b0, widx} < DEPTH_V)) begin
         mem[widx] <= wdat;
      end
   end

   // Indices past DEPTH (non power-of-two tables) read as an all-zero entry.
   assign rdat = ({1'b0, ridx} < DEPTH_V) ? mem[ridx] : '0;
endmodule

// File: rtl/mem_write_monitor.sv
// Checks observed data-memory writes in order against a programmable table; MWMON_ERRCNT_EN adds err_cnt.
// Verdict visible one cycle after the deciding edge; passive observer, exerts no backpressure.
module mem_write_monitor
   import mwmon_pkg::*;
#(
   parameter int          ADDR_W    = 32,
   parameter int          DATA_W    = 32,
   parameter int          DEPTH     = 4,
   parameter int          TIMEOUT   = 40,
   parameter int unsigned IGNORE_LO = 96,
   parameter int unsigned IGNORE_HI = 99,
   localparam int         IDX_W     = idx_width(DEPTH),
   localparam int         CNT_W     = $clog2(TIMEOUT + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               exp_we,
   input  logic [IDX_W-1:0]   exp_idx,
   input  logic [ADDR_W-1:0]  exp_addr,
   input  logic [DATA_W-1:0]  exp_data,
   input  logic [IDX_W:0]     exp_count,
   mem_write_monitor_if.slave mem,
   output logic               done,
   output logic               pass,
   output logic               fail,
   output logic               timeout,
   output logic [IDX_W:0]     match_cnt,
   output logic [CNT_W-1:0]   cycles,
   output logic [ADDR_W-1:0]  fail_addr,
`ifdef MWMON_ERRCNT_EN
   output logic [IDX_W:0]     err_cnt,
`endif
   output logic [DATA_W-1:0]  fail_data
);
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   localparam logic [IDX_W:0]   DEPTH_V = (IDX_W + 1)'(DEPTH);
   localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(TIMEOUT - 1);

   mwmon_state_e      state_q, state_d;
   logic [IDX_W:0]    cnt_q, cnt_d;
   logic [IDX_W:0]    match_d;
   logic [CNT_W-1:0]  cycles_d;
   logic [ADDR_W-1:0] faddr_d;
   logic [DATA_W-1:0] fdata_d;
`ifdef MWMON_ERRCNT_EN
   logic [IDX_W:0]    err_d;
`endif

   entry_t rd_e;
   entry_t obs_e;
   logic   ignored;
   logic   mism;
   logic   wr_event;

   mwmon_table #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W),
      .W     (ADDR_W + DATA_W)
   ) u_table (
      .clk   (clk),
      .reset (reset),
      .we    (exp_we && (state_q != RUN)),
      .widx  (exp_idx),
      .wdat  ({exp_addr, exp_data}),
      .ridx  (match_cnt[IDX_W-1:0]),
      .rdat  (rd_e)
   );

   assign obs_e    = entry_t'({mem.DataAdr, mem.WriteData});
   assign ignored  = (in_ignore(64'(mem.DataAdr), 64'(IGNORE_LO), 64'(IGNORE_HI)) === 1'b1);
   // Case inequality so X/Z on the observed bus counts as a mismatch.
   assign mism     = (obs_e !== rd_e);
   assign wr_event = (mem.MemWrite === 1'b1) && !ignored;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      match_d  = match_cnt;
      cycles_d = cycles;
      faddr_d  = fail_addr;
      fdata_d  = fail_data;
`ifdef MWMON_ERRCNT_EN
      err_d    = err_cnt;
`endif
      case (state_q)
         RUN: begin
            if (cnt_q == '0) begin
               state_d = PASS;
            end else if (wr_event) begin
               match_d = match_cnt + 1'b1;
               if (mism) begin
`ifdef MWMON_ERRCNT_EN
                  if (err_cnt == '0) begin
                     faddr_d = mem.DataAdr;
                     fdata_d = mem.WriteData;
                  end
                  if (err_cnt != '1) begin
                     err_d = err_cnt + 1'b1;
                  end
`else
                  match_d = match_cnt;
                  faddr_d = mem.DataAdr;
                  fdata_d = mem.WriteData;
                  state_d = FAIL;
`endif
               end
               if ((state_d == RUN) && (match_d == cnt_q)) begin
`ifdef MWMON_ERRCNT_EN
                  state_d = (err_d == '0) ? PASS : FAIL;
`else
                  state_d = PASS;
`endif
               end
            end
            // A verdict reached this cycle wins over the watchdog; cycles freezes on exit.
            if (state_d == RUN) begin
               if (cycles == LAST_CYC) begin
                  state_d = TOUT;
               end else begin
                  cycles_d = cycles + CNT_W'(1);
               end
            end
         end
         default: begin
            if (start) begin
               state_d  = RUN;
               cnt_d    = (exp_count > DEPTH_V) ? DEPTH_V : exp_count;
               match_d  = '0;
               cycles_d = '0;
               faddr_d  = '0;
               fdata_d  = '0;
`ifdef MWMON_ERRCNT_EN
               err_d    = '0;
`endif
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         match_cnt <= '0;
         cycles    <= '0;
         fail_addr <= '0;
         fail_data <= '0;
`ifdef MWMON_ERRCNT_EN
         err_cnt   <= '0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         match_cnt <= match_d;
         cycles    <= cycles_d;
         fail_addr <= faddr_d;
         fail_data <= fdata_d;
`ifdef MWMON_ERRCNT_EN
         err_cnt   <= err_d;
`endif
      end
   end

   assign pass    = (state_q == PASS);
   assign fail    = (state_q == FAIL);
   assign timeout = (state_q == TOUT);
   assign done    = pass | fail | timeout;
endmodule

// File: doc/mem_write_monitor.md
Name: mem_write_monitor

Overview:
- Parametrised, synthesizable checker for the processor data-memory write port (MemWrite/DataAdr/WriteData).
- Holds a programmable table of expected (address, data) writes and checks observed writes against it in order.
- Writes that fall in a configurable scratch address window are ignored; a watchdog bounds the run.
- Reports pass, fail or timeout plus diagnostics. Sits beside `top` in benches and on FPGA builds as a self-check.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- DEPTH, 4, number of expected-write entries (≥1); IDX_W = $clog2(DEPTH), minimum 1.
- TIMEOUT, 40, cycles allowed in RUN before timeout; CNT_W = $clog2(TIMEOUT+1).
- IGNORE_LO, 96, lowest ignored address (inclusive).
- IGNORE_HI, 99, highest ignored address (inclusive).

Ports:
- clk, input, 1, clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, arms a run.
- exp_we, input, 1, table write strobe.
- exp_idx, input, IDX_W, table entry index.
- exp_addr, input, ADDR_W, expected address.
- exp_data, input, DATA_W, expected data.
- exp_count, input, IDX_W+1, number of valid entries; sampled on start.
- MemWrite, input, 1, observed write enable.
- DataAdr, input, ADDR_W, observed address.
- WriteData, input, DATA_W, observed data.
- done, output, 1, run finished (any verdict).
- pass, output, 1, all expected writes matched.
- fail, output, 1, mismatch detected.
- timeout, output, 1, watchdog expired.
- match_cnt, output, IDX_W+1, expected writes matched so far.
- cycles, output, CNT_W, cycles spent in RUN.
- fail_addr, output, ADDR_W, address of the first offending write.
- fail_data, output, DATA_W, data of the first offending write.

Behaviour:
- The interface has one clock, clk. Reset is synchronous and active-high (reset); everything is sampled at the rising edge of clk.
- Reset: state goes to IDLE; all outputs are 0; table entries are cleared to 0; the internal count is 0.
- States are IDLE, RUN, PASS, FAIL and TOUT. PASS, FAIL and TOUT are sticky until reset or start.
- Table writes (exp_we) take effect only in IDLE or a terminal state. They are ignored in RUN.
- start in IDLE or a terminal state:
  - Moves the block to RUN.
  - Latches min(exp_count, DEPTH).
  - Clears match_cnt, cycles, fail_addr, fail_data and all verdicts.
  - Keeps the table contents.
- start in RUN is ignored.
- If the latched count is 0, the block goes RUN→PASS on the first RUN cycle.
- In RUN, cycles increments every cycle.
- A write event is MemWrite=1 at a rising edge.
  - Address in [IGNORE_LO, IGNORE_HI]: no effect.
  - Otherwise, compare with table[match_cnt].
  - Equal: match_cnt increments. When it reaches the count, the next state is PASS.
  - Not equal: the next state is FAIL; fail_addr and fail_data capture the write.
- Comparisons use === semantics: any X/Z on DataAdr or WriteData during a non-ignored event is a mismatch.
- Timeout: if cycles == TIMEOUT-1 and no PASS/FAIL is decided this cycle, the next state is TOUT. A verdict decided in the same cycle takes priority over TOUT.
- Latency: the verdict is visible one cycle after the deciding edge.
  - done = pass | fail | timeout.
  - Exactly one verdict is high when done=1.
- reset mid-RUN aborts to IDLE and clears all outputs and the table.

Optional Feature:
- MWMON_ERRCNT_EN
- Defined:
  - Adds output err_cnt, width IDX_W+1, saturating.
  - A mismatch does not terminate the run: err_cnt increments, match_cnt advances, and fail_addr/fail_data capture the first mismatch only.
  - When match_cnt reaches the count: pass=1 if err_cnt==0, else fail=1.
  - Timeout rules are unchanged.
- Undefined: the first mismatch goes to FAIL, and the err_cnt port does not exist.

Decomposition:
- Package mwmon_pkg holds:
  - state enum mwmon_state_e (IDLE, RUN, PASS, FAIL, TOUT);
  - entry struct (addr, data), parametrised through a typedef in the module;
  - the ignore-window helper function in_ignore(addr, lo, hi).
- Sub-module mwmon_table:
  - DEPTH×(ADDR_W+DATA_W) register file;
  - one synchronous write port, one combinational read port;
  - synchronous clear on reset.

Test Plan:
- Load {(100,7)}, count=1, start. Drive writes (96,3) then (100,7) → pass=1 one cycle after the second write; match_cnt=1; fail=0.
- Load {(100,7)}, start. Drive write (104,7) → fail=1, fail_addr=104, fail_data=7, match_cnt=0.
- Load {(100,7)}, start. Drive no writes → timeout=1 after exactly 40 RUN cycles; cycles=39 at the transition.
- Load 4 entries. On the cycle with cycles==39, drive the 4th matching write → pass=1, timeout=0.
- count=0, start → pass=1 on the second cycle. Then assert reset mid-RUN of a fresh run → all outputs 0, state IDLE.
- With MWMON_ERRCNT_EN: 3 entries, 2nd write wrong (data 5 instead of 9) → run continues; after the 3rd write fail=1, err_cnt=1, fail_data=5.
